// File: rtl/toggle_strobe_rx.sv
// ---------------------------------------------------------------------------
// toggle_strobe_rx : receive endpoint of a toggle-flag strobe crossing with
//                    a 2-entry valid/ready buffer.            rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module toggle_strobe_rx #(
  parameter int WIDTH = 8,
  parameter int DELAY = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_toggle_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             ack_toggle_out,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [CNT_W-1:0] rx_count
);

  localparam int PCW = $clog2(DELAY + 1);

  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

  logic [DELAY-1:0] sync_q, sync_d;
  logic             ref_flag_q, ref_flag_d;
  state_t           state_q, state_d;
  logic [PCW-1:0]   prime_q, prime_d;
  occ_t             occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             ack_q, ack_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;

  logic evt, pop, push_ok, drop;

  always_comb begin
    sync_d     = {sync_q[DELAY-2:0], req_toggle_in};
    ref_flag_d = sync_q[DELAY-1];

    // While priming, the reference flop absorbs whatever level the sender left behind.
    state_d = state_q;
    prime_d = prime_q;
    if (state_q == PRIME) begin
      if (prime_q == PCW'(DELAY)) state_d = RUN;
      else                        prime_d = prime_q + 1'b1;
    end

    evt     = (sync_q[DELAY-1] ^ ref_flag_q) && (state_q == RUN);
    pop     = data_valid_q && data_ready;
    push_ok = evt && ((occ_q != FULL) || pop);
    drop    = evt && (occ_q == FULL) && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   occ_d = (occ_q == EMPTY) ? ONE : FULL;
      2'b01:   occ_d = (occ_q == FULL) ? ONE : EMPTY;
      default: occ_d = occ_q;
    endcase

    // Head is registered from next-state pointers so it lines up with data_valid.
    data_valid_d = (occ_d != EMPTY);
    data_out_d   = data_valid_d ? mem_d[rd_ptr_d] : data_out_q;

    ack_d      = ack_q ^ pop;
    overrun_d  = drop | (overrun_q & ~overrun_clr);
    rx_count_d = rx_count_q + CNT_W'(push_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      ref_flag_q   <= 1'b0;
      state_q      <= PRIME;
      prime_q      <= '0;
      occ_q        <= EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      overrun_q    <= 1'b0;
      rx_count_q   <= '0;
    end else begin
      sync_q       <= sync_d;
      ref_flag_q   <= ref_flag_d;
      state_q      <= state_d;
      prime_q      <= prime_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      ack_q        <= ack_d;
      overrun_q    <= overrun_d;
      rx_count_q   <= rx_count_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_valid     = data_valid_q;
  assign ack_toggle_out = ack_q;
  assign overrun        = overrun_q;
  assign rx_count       = rx_count_q;

endmodule

`default_nettype wire

// File: doc/toggle_strobe_rx.md
Name: toggle_strobe_rx

Overview:
- Receive-side endpoint of the toggle-flag strobe crossing, living entirely in the destination clock domain.
- The sender domain flips a flag once per strobe and holds the captured data word stable.
- This block synchronises the flag, detects each flip, and captures the word into a 2-entry buffer with a valid/ready consumer interface.
- It returns an acknowledge toggle to the sender on every consumed word, and flags overruns and counts accepted strobes.

Parameters:
- WIDTH, 8: data word width in bits.
- DELAY, 2: synchroniser depth in flops (minimum 2).
- CNT_W, 16: width of the accepted-strobe counter.

Ports:
- clk  input  1  destination-domain clock.
- rst_n  input  1  asynchronous active-low reset; clears all state.
- req_toggle_in  input  1  sender flag from the foreign domain; each level change is one strobe.
- data_in  input  WIDTH  sender data word; stable for at least DELAY+2 clk cycles after each flag change.
- data_out  output  WIDTH  head-of-buffer word.
- data_valid  output  1  buffer non-empty.
- data_ready  input  1  consumer pop; a pop occurs when data_valid && data_ready.
- ack_toggle_out  output  1  registered; flips once per pop.
- overrun  output  1  sticky; a strobe arrived while the buffer was full and no pop occurred.
- overrun_clr  input  1  clears overrun.
- rx_count  output  CNT_W  accepted strobes, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: sync chain = 0, ref flop = 0, state = PRIME, buffer empty, data_valid = 0, data_out = 0, ack_toggle_out = 0, overrun = 0, rx_count = 0, prime counter = 0.
- Sync chain: sync <= {sync[DELAY-2:0], req_toggle_in} every clk.
- ref flop: ref <= sync[DELAY-1] every clk.
- Event: evt = (sync[DELAY-1] ^ ref) && state == RUN.
- PRIME state:
  - Lasts DELAY+1 cycles after reset release.
  - ref tracks the sync chain; evt is suppressed.
  - A flag left at 1 by the sender therefore causes no spurious strobe.
  - A flag change during PRIME is lost by design.
- PRIME -> RUN when the prime counter reaches DELAY. RUN persists until reset.
- Latency: if req_toggle_in flips before clk edge k, evt is high in the cycle after edge k+DELAY-1. data_in is captured and data_valid = 1 after edge k+DELAY, when the buffer was empty.
- Buffer: 2-entry FIFO, occupancy EMPTY / ONE / FULL, with rd/wr pointers of 1 bit each.
  - Push on evt: write data_in.
  - Pop on data_valid && data_ready.
- Push/pop rules:
  - EMPTY, push only: -> ONE.
  - ONE, push only: -> FULL.
  - ONE, pop only: -> EMPTY.
  - FULL, pop only: -> ONE.
  - ONE, push and pop same cycle: stays ONE; data_out shows the new word next cycle.
  - FULL, push and pop same cycle: push accepted, stays FULL, no overrun.
  - FULL, push without pop: word dropped, overrun <= 1, rx_count unchanged.
  - EMPTY, pop: impossible since data_valid = 0; ignored.
- Outputs:
  - data_out is the registered head entry, valid whenever data_valid = 1.
  - data_out is undefined-but-stable when the buffer is empty; it holds its last value.
- rx_count increments by 1 per accepted push and wraps from all-ones to 0.
- ack_toggle_out flips on the edge that completes each pop.
- overrun: a set in the same cycle as overrun_clr wins (stays 1).
- Reset asserted mid-transfer: everything returns to reset values at once and buffered words are discarded. The sender is required to be reset in the same window.
- Back-to-back strobes: two flag flips on consecutive sender cycles may merge after synchronisation. Guaranteed spacing is the sender's duty: at most one flip per DELAY+2 clk cycles.

Test Plan:
- Reset release with req_toggle_in = 1, WIDTH = 8, DELAY = 2 -> no data_valid within 20 cycles; rx_count = 0.
- In RUN, flip flag with data_in = 0xA5 -> data_valid rises at edge k+2. Then:
  - data_out = 0xA5 and rx_count = 1.
  - Pop -> ack_toggle_out flips to 1 and data_valid falls.
- Three strobes (0x11, 0x22, 0x33) spaced 5 cycles, data_ready = 0 ->
  - Buffer holds 0x11 and 0x22; overrun = 1 and rx_count = 2.
  - Pops return 0x11 then 0x22; ack toggles twice.
- Buffer FULL, strobe evt coincides with a pop -> no overrun and rx_count increments. Successive pops return the old second word, then the new word.
- overrun_clr pulsed while an overrun event occurs in the same cycle -> overrun stays 1. A later overrun_clr alone -> overrun = 0.
- rx_count preset by 65535 accepted strobes plus one more -> rx_count = 0. Assert rst_n = 0 mid-buffer -> data_valid, ack_toggle_out and overrun all 0 immediately.
